// File: rtl/banner_pkg.sv
// Shared types and constants for the banner overlay.
package banner_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SHOW   = 2'd2
  } state_e;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // 4-bit-per-channel pixel
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb4_t;

endpackage

// File: rtl/banner_seq.sv
// Banner sequencer: frame-start detection, per-frame position latch,
// IDLE/REVEAL/SHOW state machine with the reveal column, and the optional
// blink (enabled by defining BANNER_BLINK_EN).
module banner_seq
  import banner_pkg::*;
#(
  parameter int unsigned IMG_W        = 360,
  parameter int unsigned REVEAL_STEP  = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned COL_W        = $clog2(IMG_W + 1)
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             show,
  output logic [9:0]       px,
  output logic [9:0]       py,
  output state_e           state,
  output logic [COL_W-1:0] reveal_col,
  output logic             blink_on,
  output logic             banner_done
);

  // A zero step would never finish the reveal; a zero blink period is meaningless.
  if (BLINK_FRAMES < 32'd1 || REVEAL_STEP < 32'd1) begin : g_bad_param
    $error("banner_seq: BLINK_FRAMES and REVEAL_STEP must be at least 1");
  end

  logic             at_origin_s;
  logic             frame_start_s;
  logic             origin_q;
  logic [9:0]       px_d, px_q, py_d, py_q;
  state_e           state_d, state_q;
  logic [COL_W-1:0] col_d, col_q, base_s, sat_s;
  logic [31:0]      sum_s;
  logic             done_q;

  // Edge-detect the origin so a held (0,0) still gives a single pulse.
  assign at_origin_s   = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_start_s = at_origin_s && !origin_q;

  // Position latches only at frame start; the origin pixel already sees the new value.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (frame_start_s) begin
      px_d = pos_x;
      py_d = pos_y;
    end else begin
      px_d = px_q;
      py_d = py_q;
    end
  end

  // Next-state and reveal column; dropping show wins over everything.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    base_s  = (state_q == ST_IDLE) ? {COL_W{1'b0}} : col_q;
    sum_s   = 32'(base_s) + REVEAL_STEP;
    sat_s   = (sum_s >= IMG_W) ? COL_W'(IMG_W) : COL_W'(sum_s);
    if (!show) begin
      state_d = ST_IDLE;
      col_d   = {COL_W{1'b0}};
    end else if (frame_start_s) begin
      case (state_q)
        ST_IDLE, ST_REVEAL: begin
          col_d   = sat_s;
          state_d = (sat_s == COL_W'(IMG_W)) ? ST_SHOW : ST_REVEAL;
        end
        ST_SHOW: begin
          col_d   = col_q;
          state_d = ST_SHOW;
        end
        default: begin
          col_d   = {COL_W{1'b0}};
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
      col_d   = col_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      origin_q <= 1'b0;
      px_q     <= 10'd0;
      py_q     <= 10'd0;
      state_q  <= ST_IDLE;
      col_q    <= {COL_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      origin_q <= at_origin_s;
      px_q     <= px_d;
      py_q     <= py_d;
      state_q  <= state_d;
      col_q    <= col_d;
      done_q   <= (state_d == ST_SHOW);
    end
  end

`ifdef BANNER_BLINK_EN
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  logic [BLK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic             blink_on_d, blink_on_q;

  // Count frame starts in SHOW, toggling visibility every BLINK_FRAMES; start visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (state_d != ST_SHOW) begin
      blink_cnt_d = {BLK_W{1'b0}};
      blink_on_d  = 1'b1;
    end else if (state_q == ST_SHOW && frame_start_s) begin
      if (32'(blink_cnt_q) + 32'd1 == BLINK_FRAMES) begin
        blink_cnt_d = {BLK_W{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        blink_on_d  = blink_on_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
    end
  end

  // Blink registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= {BLK_W{1'b0}};
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  assign px          = px_d;
  assign py          = py_d;
  assign state       = state_q;
  assign reveal_col  = col_q;
  assign banner_done = done_q;

endmodule

// File: rtl/banner_overlay.sv
// Banner overlay: composites a scaled, keyed, palette-indexed ROM image over
// the background stream with a fixed 3-cycle latency and a per-frame reveal wipe.
// Optional blink in SHOW is enabled by defining BANNER_BLINK_EN.
module banner_overlay
  import banner_pkg::*;
#(
  parameter int unsigned IMG_W        = 360,
  parameter int unsigned IMG_H        = 75,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned KEY_IDX      = 0,
  parameter int unsigned REVEAL_STEP  = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned ADDR_W       = $clog2(IMG_W * IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              show,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              banner_done
);

  localparam int unsigned COL_W = $clog2(IMG_W + 1);

  logic [9:0]       px_s, py_s;
  state_e           state_s;
  logic [COL_W-1:0] reveal_col_s;
  logic             blink_on_s;

  banner_seq #(
    .IMG_W       (IMG_W),
    .REVEAL_STEP (REVEAL_STEP),
    .BLINK_FRAMES(BLINK_FRAMES),
    .COL_W       (COL_W)
  ) u_seq (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .show       (show),
    .px         (px_s),
    .py         (py_s),
    .state      (state_s),
    .reveal_col (reveal_col_s),
    .blink_on   (blink_on_s),
    .banner_done(banner_done)
  );

  logic [10:0]       dx_s, dy_s;
  logic [9:0]        lx_d, ly_s;
  logic              in_box_d;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  rgb4_t             bg_s;

  logic              in_box1_q, in_box2_q;
  logic [9:0]        lx1_q, lx2_q;
  logic              blank1_q, blank2_q;
  rgb4_t             bg1_q, bg2_q;

  logic              visible_s;
  rgb4_t             pal_s, rgb_d, rgb_q;

  assign bg_s  = '{red: bg_red, green: bg_green, blue: bg_blue};
  assign pal_s = '{red: pal_red, green: pal_green, blue: pal_blue};

  // S1 combinational: offset with borrow (so right/bottom never wrap), scale by shift, address.
  always_comb begin
    dx_s     = {1'b0, DrawX} - {1'b0, px_s};
    dy_s     = {1'b0, DrawY} - {1'b0, py_s};
    lx_d     = dx_s[9:0] >> SCALE_LOG2;
    ly_s     = dy_s[9:0] >> SCALE_LOG2;
    in_box_d = !dx_s[10] && !dy_s[10] && (32'(lx_d) < IMG_W) && (32'(ly_s) < IMG_H);
    if (in_box_d) begin
      rom_addr_d = ADDR_W'(32'(ly_s) * IMG_W + 32'(lx_d));
    end else begin
      rom_addr_d = {ADDR_W{1'b0}};
    end
  end

  // S1/S2 pipeline: address to ROM, side-band delayed to line up with rom_q.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= {ADDR_W{1'b0}};
      in_box1_q  <= 1'b0;
      lx1_q      <= 10'd0;
      blank1_q   <= 1'b0;
      bg1_q      <= '{red: 4'd0, green: 4'd0, blue: 4'd0};
      in_box2_q  <= 1'b0;
      lx2_q      <= 10'd0;
      blank2_q   <= 1'b0;
      bg2_q      <= '{red: 4'd0, green: 4'd0, blue: 4'd0};
    end else begin
      rom_addr_q <= rom_addr_d;
      in_box1_q  <= in_box_d;
      lx1_q      <= lx_d;
      blank1_q   <= blank;
      bg1_q      <= bg_s;
      in_box2_q  <= in_box1_q;
      lx2_q      <= lx1_q;
      blank2_q   <= blank1_q;
      bg2_q      <= bg1_q;
    end
  end

  // S3 combinational: keyed, revealed, state-gated composite.
  always_comb begin
    visible_s = blank2_q && in_box2_q && (rom_q != IDX_W'(KEY_IDX)) &&
                (32'(lx2_q) < 32'(reveal_col_s)) && (state_s != ST_IDLE) && blink_on_s;
    if (!blank2_q) begin
      rgb_d = '{red: 4'd0, green: 4'd0, blue: 4'd0};
    end else if (visible_s) begin
      rgb_d = pal_s;
    end else begin
      rgb_d = bg2_q;
    end
  end

  // S3 output register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '{red: 4'd0, green: 4'd0, blue: 4'd0};
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pal_index = rom_q;
  assign red       = rgb_q.red;
  assign green     = rgb_q.green;
  assign blue      = rgb_q.blue;

endmodule

// File: tb/tb_banner_overlay.sv
// Directed, scoreboard-based bench for banner_overlay (24x4 image, scale x2).
module tb_banner_overlay;
  import banner_pkg::*;

  localparam int unsigned IMG_W        = 24;
  localparam int unsigned IMG_H        = 4;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned SCALE_LOG2   = 1;
  localparam int unsigned KEY_IDX      = 0;
  localparam int unsigned REVEAL_STEP  = 8;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned ADDR_W       = $clog2(IMG_W * IMG_H);
  localparam logic [11:0] BG           = 12'hA53;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY, pos_x, pos_y;
  logic              blank, show;
  logic [3:0]        bg_red, bg_green, bg_blue;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red, pal_green, pal_blue;
  logic [3:0]        red, green, blue;
  logic              banner_done;

  int n_pass  = 0;
  int n_total = 0;

  // bench model of the sequencer
  int m_state = 0;
  int m_col   = 0;
  int m_px    = 0;
  int m_py    = 0;

  typedef struct {
    string       tag;
    bit          chk;
    logic [11:0] exp;
  } sb_t;
  sb_t sbq[$];

  banner_overlay #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IDX_W(IDX_W), .SCALE_LOG2(SCALE_LOG2),
    .KEY_IDX(KEY_IDX), .REVEAL_STEP(REVEAL_STEP), .BLINK_FRAMES(BLINK_FRAMES),
    .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .show(show),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .banner_done(banner_done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] texel(input int a);
    return 3'((a * 3 + 1) % 8);
  endfunction

  function automatic logic [11:0] pal_rgb(input logic [2:0] i);
    return {1'b1, i, i, 1'b0, 1'b0, ~i};
  endfunction

  // external synchronous ROM and combinational palette
  always @(posedge vga_clk) rom_q <= texel(int'(rom_addr));
  assign pal_red   = {1'b1, pal_index};
  assign pal_green = {pal_index, 1'b0};
  assign pal_blue  = {1'b0, ~pal_index};

  function automatic logic [11:0] model_px(input int x, input int y, input logic b,
                                            input logic [11:0] bgv);
    int dx, dy, lx, ly;
    logic [2:0] idx;
    dx = x - m_px;
    dy = y - m_py;
    if (!b) return 12'h000;
    if (dx < 0 || dy < 0) return bgv;
    lx = dx >> SCALE_LOG2;
    ly = dy >> SCALE_LOG2;
    if (lx >= int'(IMG_W) || ly >= int'(IMG_H)) return bgv;
    idx = texel(ly * int'(IMG_W) + lx);
    if (idx == 3'(KEY_IDX) || lx >= m_col || m_state == 0) return bgv;
    return pal_rgb(idx);
  endfunction

  task automatic step(input int x, input int y, input logic b, input logic [11:0] bgv,
                      input bit c, input string tag);
    @(posedge vga_clk);
    #1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    {bg_red, bg_green, bg_blue} = bgv;
    sbq.push_back('{tag, c, model_px(x, y, b, bgv)});
  endtask

  task automatic pix(input int x, input int y, input string tag);
    step(x, y, 1'b1, BG, 1'b1, tag);
  endtask

  task automatic idle();
    step(639, 479, 1'b0, BG, 1'b0, "idle");
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // one guard cycle, then a frame-start cycle; model advances with it
  task automatic frame();
    idle();
    step(0, 0, 1'b0, BG, 1'b0, "fs");
    m_px = int'(pos_x);
    m_py = int'(pos_y);
    if (show) begin
      if (m_state != 2) begin
        m_col   = (m_state == 0 ? 0 : m_col) + int'(REVEAL_STEP);
        if (m_col >= int'(IMG_W)) m_col = int'(IMG_W);
        m_state = (m_col == int'(IMG_W)) ? 2 : 1;
      end
    end
  endtask

  task automatic set_show(input logic v);
    idle();
    idle();
    show = v;
    if (!v) begin
      m_state = 0;
      m_col   = 0;
    end
  endtask

  // output scoreboard: outputs lag the driven inputs by three cycles
  always @(negedge vga_clk) begin
    if (sbq.size() >= 4) begin
      sb_t e;
      e = sbq.pop_front();
      if (e.chk) begin
        n_total++;
        assert ({red, green, blue} === e.exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", e.tag, {red, green, blue}, e.exp);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    DrawX = 10'd639; DrawY = 10'd479; blank = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0; show = 1'b0;
    {bg_red, bg_green, bg_blue} = BG;

    repeat (3) idle();
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_done", 32'(banner_done), 32'h0);
    reset_n = 1'b1;

    // IDLE: nothing drawn; address path with scale x2
    frame();
    pix(7, 3, "idle_bg");
    pix(40, 0, "idle_bg2");
    chk("addr_scale", 32'(rom_addr), 32'd27);
    pix(100, 100, "outside");
    chk("addr_lx20", 32'(rom_addr), 32'd20);
    pix(7, 3, "idle_bg3");
    chk("addr_outside", 32'(rom_addr), 32'd0);

    // reveal progression
    set_show(1'b1);
    frame();
    pix(7, 3, "rev8_vis");
    chk("done_rev8", 32'(banner_done), 32'h0);
    pix(20, 2, "rev8_hidden");
    frame();
    pix(40, 0, "lx20_col16");
    chk("done_rev16", 32'(banner_done), 32'h0);
    frame();
    pix(40, 0, "lx20_col24");
    chk("done_show", 32'(banner_done), 32'h1);

    // transparent key, and blanking
    pix(10, 0, "key_bg");
    step(10, 0, 1'b0, BG, 1'b1, "key_blank");
    step(7, 3, 1'b0, 12'h5C3, 1'b1, "vis_blank");

    // clipping at right/bottom, no wrap
    pos_x = 10'd630; pos_y = 10'd470;
    frame();
    pix(639, 479, "clip_bottom");
    pix(639, 475, "clip_in");
    pix(5, 475, "no_wrap");

    // position beyond the screen
    pos_x = 10'd1000; pos_y = 10'd10;
    frame();
    pix(639, 11, "offscreen");

    // mid-frame position change waits for the next frame start
    pos_x = 10'd0; pos_y = 10'd0;
    frame();
    pix(7, 3, "pos_a");
    pos_x = 10'd100;
    pix(7, 3, "pos_hold");
    frame();
    pix(7, 3, "pos_new_old_spot");
    pix(107, 3, "pos_moved");

    // show drop mid-REVEAL
    pos_x = 10'd0;
    set_show(1'b0);
    pix(7, 3, "show_off_bg");
    chk("done_drop_show", 32'(banner_done), 32'h0);
    frame();
    set_show(1'b1);
    frame();
    frame();
    pix(7, 3, "rev16_vis");
    set_show(1'b0);
    pix(7, 3, "drop_bg");
    chk("done_drop_rev", 32'(banner_done), 32'h0);
    set_show(1'b1);
    pix(7, 3, "reassert_wait");
    frame();
    pix(20, 2, "restart_col8");
    pix(7, 3, "restart_vis");

    // asynchronous reset mid-line from SHOW
    frame();
    frame();
    pix(7, 3, "pre_rst0");
    chk("done_pre_rst", 32'(banner_done), 32'h1);
    pix(7, 3, "pre_rst1");
    pix(7, 3, "pre_rst2");
    pix(7, 3, "pre_rst3");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("async_rst_done", 32'(banner_done), 32'h0);
    sbq.delete();
    m_state = 0; m_col = 0; m_px = 0; m_py = 0;
    step(639, 479, 1'b0, BG, 1'b1, "in_rst0");
    step(639, 479, 1'b0, BG, 1'b1, "in_rst1");
    reset_n = 1'b1;
    pix(7, 3, "post_rst_idle");
    frame();
    pix(7, 3, "post_rst_vis");

    repeat (5) idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
